// File: rtl/regfile_writeback_arbiter.sv
// Shares the single register-file write port between two writeback requesters.
// Each requester has a small FIFO, the FIFOs are drained round-robin, and a scoreboard flags pending rd writes.

module WritebackFifo #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_push,
    input  logic [3:0]  i_pushRd,
    input  logic [31:0] i_pushData,
    input  logic        i_pop,
    output logic [3:0]  o_headRd,
    output logic [31:0] o_headData,
    output logic        o_empty,
    output logic        o_full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [3:0]    r_rdMem   [DEPTH];
    logic [31:0]   r_dataMem [DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            if (i_pop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!i_push && i_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Payload storage needs no reset; the count alone says which slots are live.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_rdMem[r_wrPtr]   <= i_pushRd;
            r_dataMem[r_wrPtr] <= i_pushData;
        end
    end

    assign o_headRd   = r_rdMem[r_rdPtr];
    assign o_headData = r_dataMem[r_rdPtr];
    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == CW'(DEPTH));
endmodule

module regfile_writeback_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_rd,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_rd,
    input  logic [31:0] b_data,
    input  logic [4:0]  rs1_query,
    input  logic [4:0]  rs2_query,
    output logic        rs1_pending,
    output logic        rs2_pending,
    output logic        wen,
    output logic        register_file_enable,
    output logic [4:0]  rd_address,
    output logic [31:0] data,
    output logic        addr_err
);
    logic [15:0] r_pend;
    logic        r_prioB;
    logic        r_wen;
    logic [4:0]  r_rdAddr;
    logic [31:0] r_data;
    logic        r_addrErr;

    logic        w_aLegal;
    logic        w_bLegal;
    logic        w_conflict;
    logic        w_aFire;
    logic        w_bFire;
    logic        w_aPush;
    logic        w_bPush;
    logic        w_aEmpty;
    logic        w_bEmpty;
    logic        w_aFull;
    logic        w_bFull;
    logic [3:0]  w_aHeadRd;
    logic [3:0]  w_bHeadRd;
    logic [31:0] w_aHeadData;
    logic [31:0] w_bHeadData;
    logic        w_grantA;
    logic        w_grantB;
    logic        w_popValid;
    logic [3:0]  w_popRd;
    logic [31:0] w_popData;
    logic [15:0] w_setMask;
    logic [15:0] w_clrMask;

    assign w_aLegal   = !a_rd[4] && (a_rd != 5'd0);
    assign w_bLegal   = !b_rd[4] && (b_rd != 5'd0);
    assign w_conflict = a_valid && b_valid && (a_rd == b_rd) && w_aLegal;

    // x0 and x16-x31 are always swallowed; legal writes need FIFO room, no write
    // in flight to the same rd, and priority when both ports target one rd.
    assign a_ready = !reset && (!w_aLegal ||
                     (!w_aFull && !r_pend[a_rd[3:0]] && !(w_conflict && r_prioB)));
    assign b_ready = !reset && (!w_bLegal ||
                     (!w_bFull && !r_pend[b_rd[3:0]] && !(w_conflict && !r_prioB)));

    assign w_aFire = a_valid && a_ready;
    assign w_bFire = b_valid && b_ready;
    assign w_aPush = w_aFire && w_aLegal;
    assign w_bPush = w_bFire && w_bLegal;

    WritebackFifo #(.DEPTH(DEPTH)) u_fifoA (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_aPush),
        .i_pushRd   (a_rd[3:0]),
        .i_pushData (a_data),
        .i_pop      (w_grantA),
        .o_headRd   (w_aHeadRd),
        .o_headData (w_aHeadData),
        .o_empty    (w_aEmpty),
        .o_full     (w_aFull)
    );

    WritebackFifo #(.DEPTH(DEPTH)) u_fifoB (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_bPush),
        .i_pushRd   (b_rd[3:0]),
        .i_pushData (b_data),
        .i_pop      (w_grantB),
        .o_headRd   (w_bHeadRd),
        .o_headData (w_bHeadData),
        .o_empty    (w_bEmpty),
        .o_full     (w_bFull)
    );

    assign w_grantA   = !w_aEmpty && (w_bEmpty || !r_prioB);
    assign w_grantB   = !w_bEmpty && (w_aEmpty || r_prioB);
    assign w_popValid = w_grantA || w_grantB;
    assign w_popRd    = w_grantA ? w_aHeadRd : w_bHeadRd;
    assign w_popData  = w_grantA ? w_aHeadData : w_bHeadData;

    always_comb begin
        w_setMask = '0;
        w_clrMask = '0;
        if (w_aPush) begin
            w_setMask[a_rd[3:0]] = 1'b1;
        end
        if (w_bPush) begin
            w_setMask[b_rd[3:0]] = 1'b1;
        end
        if (r_wen) begin
            w_clrMask[r_rdAddr[3:0]] = 1'b1;
        end
    end

    // Set is applied after clear so a re-accept of a just-committed rd stays pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend    <= '0;
            r_prioB   <= 1'b0;
            r_wen     <= 1'b0;
            r_rdAddr  <= '0;
            r_data    <= '0;
            r_addrErr <= 1'b0;
        end else begin
            r_pend    <= (r_pend & ~w_clrMask) | w_setMask;
            r_wen     <= w_popValid;
            r_addrErr <= (w_aFire && a_rd[4]) || (w_bFire && b_rd[4]);
            if (!w_aEmpty && !w_bEmpty) begin
                r_prioB <= !r_prioB;
            end
            if (w_popValid) begin
                r_rdAddr <= {1'b0, w_popRd};
                r_data   <= w_popData;
            end
        end
    end

    assign rs1_pending = r_pend[rs1_query[3:0]] && !rs1_query[4] && (rs1_query != 5'd0);
    assign rs2_pending = r_pend[rs2_query[3:0]] && !rs2_query[4] && (rs2_query != 5'd0);

    assign wen                  = r_wen;
    assign register_file_enable = r_wen;
    assign rd_address           = r_rdAddr;
    assign data                 = r_data;
    assign addr_err             = r_addrErr;
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed bench for regfile_writeback_arbiter; the monitor matches every write
// against an expected-commit queue filled as each scenario is driven.

module tb_regfile_writeback_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, a_ready, b_valid, b_ready;
    logic [4:0]  a_rd, b_rd, rs1_query, rs2_query;
    logic [31:0] a_data, b_data;
    logic        rs1_pending, rs2_pending;
    logic        wen, register_file_enable, addr_err;
    logic [4:0]  rd_address;
    logic [31:0] data;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ExpWrite;

    ExpWrite     expQ[$];
    logic [4:0]  aRdList[$];
    logic [31:0] aDataList[$];
    logic [4:0]  bRdList[$];
    logic [31:0] bDataList[$];
    int          compareCount = 0;
    int          mismatchCount = 0;
    bit          monitorOn = 1'b0;
    int          runLen = 0;
    int          maxRun = 0;

    regfile_writeback_arbiter #(.DEPTH(2)) dut (
        .clk                  (clk),
        .reset                (reset),
        .a_valid              (a_valid),
        .a_ready              (a_ready),
        .a_rd                 (a_rd),
        .a_data               (a_data),
        .b_valid              (b_valid),
        .b_ready              (b_ready),
        .b_rd                 (b_rd),
        .b_data               (b_data),
        .rs1_query            (rs1_query),
        .rs2_query            (rs2_query),
        .rs1_pending          (rs1_pending),
        .rs2_pending          (rs2_pending),
        .wen                  (wen),
        .register_file_enable (register_file_enable),
        .rd_address           (rd_address),
        .data                 (data),
        .addr_err             (addr_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            mismatchCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input logic [4:0] rd, input logic [31:0] value);
        ExpWrite e;
        e.rd   = rd;
        e.data = value;
        expQ.push_back(e);
    endtask

    // Drives both request lists concurrently, holding each request until its handshake.
    task automatic applyStimulus(input int maxCycles);
        int ai = 0;
        int bi = 0;
        bit aFire;
        bit bFire;
        for (int c = 0; c < maxCycles && (ai < aRdList.size() || bi < bRdList.size()); c++) begin
            a_valid = (ai < aRdList.size());
            b_valid = (bi < bRdList.size());
            if (a_valid) begin
                a_rd   = aRdList[ai];
                a_data = aDataList[ai];
            end
            if (b_valid) begin
                b_rd   = bRdList[bi];
                b_data = bDataList[bi];
            end
            @(negedge clk);
            aFire = a_valid && a_ready;
            bFire = b_valid && b_ready;
            tick;
            if (aFire) ai++;
            if (bFire) bi++;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        checkOutput("stimulus_accepted", 32'(ai + bi), 32'(aRdList.size() + bRdList.size()));
        aRdList.delete();
        aDataList.delete();
        bRdList.delete();
        bDataList.delete();
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && expQ.size() != 0; i++) tick;
        tick;
        tick;
        checkOutput(tag, 32'(expQ.size()), 32'd0);
    endtask

    always @(negedge clk) begin : monitor
        ExpWrite e;
        if (monitorOn) begin
            if (wen === 1'b1) begin
                runLen++;
                if (runLen > maxRun) maxRun = runLen;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_wen", 32'(wen), 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("commit_rd", 32'(rd_address), 32'(e.rd));
                    checkOutput("commit_data", data, e.data);
                end
            end else begin
                runLen = 0;
            end
        end
    end

    initial begin
        bit bAccepted;
        int acceptCycle;
        bit seenAFull;
        bit seenBFull;
        int aNext;
        int bNext;

        reset = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0;
        a_rd = 5'd3; b_rd = 5'd4;
        a_data = '0; b_data = '0;
        rs1_query = '0; rs2_query = '0;
        tick;
        tick;
        @(negedge clk);
        checkOutput("reset_a_ready", 32'(a_ready), 32'd0);
        checkOutput("reset_b_ready", 32'(b_ready), 32'd0);
        checkOutput("reset_wen", 32'(wen), 32'd0);
        checkOutput("reset_rf_enable", 32'(register_file_enable), 32'd0);
        checkOutput("reset_rd_address", 32'(rd_address), 32'd0);
        checkOutput("reset_data", data, 32'd0);
        checkOutput("reset_addr_err", 32'(addr_err), 32'd0);
        tick;
        reset = 1'b0;
        monitorOn = 1'b1;

        $display("[TB] single write");
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF; rs1_query = 5'd5;
        pushExp(5'd5, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("single_a_ready", 32'(a_ready), 32'd1);
        checkOutput("single_pend_c0", 32'(rs1_pending), 32'd0);
        tick;
        a_valid = 1'b0;
        @(negedge clk);
        checkOutput("single_pend_c1", 32'(rs1_pending), 32'd1);
        checkOutput("single_wen_c1", 32'(wen), 32'd0);
        tick;
        @(negedge clk);
        checkOutput("single_pend_c2", 32'(rs1_pending), 32'd1);
        checkOutput("single_wen_c2", 32'(wen), 32'd1);
        checkOutput("single_rf_enable_c2", 32'(register_file_enable), 32'd1);
        checkOutput("single_rd_c2", 32'(rd_address), 32'd5);
        tick;
        @(negedge clk);
        checkOutput("single_pend_c3", 32'(rs1_pending), 32'd0);
        checkOutput("single_wen_c3", 32'(wen), 32'd0);
        drain("single_drain");

        $display("[TB] contention");
        for (int i = 0; i < 3; i++) begin
            aRdList.push_back(5'(i + 1));
            aDataList.push_back(32'hA000_0000 + 32'(i + 1));
            bRdList.push_back(5'(i + 4));
            bDataList.push_back(32'hB000_0000 + 32'(i + 4));
        end
        for (int i = 0; i < 3; i++) begin
            pushExp(5'(i + 1), 32'hA000_0000 + 32'(i + 1));
            pushExp(5'(i + 4), 32'hB000_0000 + 32'(i + 4));
        end
        maxRun = 0;
        applyStimulus(20);
        drain("contention_drain");
        checkOutput("contention_run", 32'(maxRun), 32'd6);

        $display("[TB] hazard stall");
        a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h7777_000A; rs2_query = 5'd7;
        pushExp(5'd7, 32'h7777_000A);
        pushExp(5'd7, 32'h7777_000B);
        @(negedge clk);
        checkOutput("hazard_a_ready", 32'(a_ready), 32'd1);
        tick;
        a_valid = 1'b0;
        b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h7777_000B;
        @(negedge clk);
        checkOutput("hazard_b_ready_c1", 32'(b_ready), 32'd0);
        checkOutput("hazard_pend_c1", 32'(rs2_pending), 32'd1);
        tick;
        @(negedge clk);
        checkOutput("hazard_b_ready_c2", 32'(b_ready), 32'd0);
        checkOutput("hazard_wen_c2", 32'(wen), 32'd1);
        tick;
        @(negedge clk);
        checkOutput("hazard_b_ready_c3", 32'(b_ready), 32'd1);
        tick;
        b_valid = 1'b0;
        drain("hazard_drain");

        $display("[TB] same-cycle conflict");
        reset = 1'b1;
        tick;
        reset = 1'b0;
        a_valid = 1'b1; a_rd = 5'd9; a_data = 32'h9999_000A;
        b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h9999_000B;
        pushExp(5'd9, 32'h9999_000A);
        pushExp(5'd9, 32'h9999_000B);
        @(negedge clk);
        checkOutput("conflict_a_ready", 32'(a_ready), 32'd1);
        checkOutput("conflict_b_ready", 32'(b_ready), 32'd0);
        tick;
        a_valid = 1'b0;
        bAccepted = 1'b0;
        acceptCycle = -1;
        for (int i = 0; i < 10 && !bAccepted; i++) begin
            @(negedge clk);
            if (b_ready === 1'b1) begin
                bAccepted = 1'b1;
                acceptCycle = i;
            end
            tick;
        end
        b_valid = 1'b0;
        checkOutput("conflict_b_accepted", 32'(bAccepted), 32'd1);
        checkOutput("conflict_b_wait", 32'(acceptCycle), 32'd2);
        drain("conflict_drain");

        $display("[TB] illegal and zero addresses");
        rs1_query = 5'd1; rs2_query = 5'd0;
        b_valid = 1'b1; b_rd = 5'd17; b_data = 32'h0000_0011;
        @(negedge clk);
        checkOutput("illegal_b_ready", 32'(b_ready), 32'd1);
        checkOutput("illegal_err_c0", 32'(addr_err), 32'd0);
        tick;
        b_valid = 1'b0;
        a_valid = 1'b1; a_rd = 5'd0; a_data = 32'h0000_0022;
        @(negedge clk);
        checkOutput("zero_a_ready", 32'(a_ready), 32'd1);
        checkOutput("illegal_err_c1", 32'(addr_err), 32'd1);
        checkOutput("illegal_wen_c1", 32'(wen), 32'd0);
        checkOutput("illegal_pend_c1", 32'(rs1_pending), 32'd0);
        tick;
        a_valid = 1'b0;
        @(negedge clk);
        checkOutput("illegal_err_c2", 32'(addr_err), 32'd0);
        checkOutput("illegal_wen_c2", 32'(wen), 32'd0);
        tick;
        @(negedge clk);
        checkOutput("illegal_wen_c3", 32'(wen), 32'd0);
        checkOutput("illegal_pend_c3", 32'(rs1_pending), 32'd0);
        checkOutput("zero_pend_c3", 32'(rs2_pending), 32'd0);
        tick;

        $display("[TB] reset mid-flight");
        monitorOn = 1'b0;
        seenAFull = 1'b0;
        seenBFull = 1'b0;
        aNext = 1;
        bNext = 9;
        for (int c = 0; c < 4; c++) begin
            a_valid = 1'b1; a_rd = 5'(aNext); a_data = 32'hF0 + 32'(aNext);
            b_valid = 1'b1; b_rd = 5'(bNext); b_data = 32'hF0 + 32'(bNext);
            @(negedge clk);
            if (a_ready === 1'b0) seenAFull = 1'b1;
            if (b_ready === 1'b0) seenBFull = 1'b1;
            tick;
            if (a_ready === 1'b1) aNext++;
            if (b_ready === 1'b1) bNext++;
        end
        checkOutput("flight_a_full_seen", 32'(seenAFull), 32'd1);
        checkOutput("flight_b_full_seen", 32'(seenBFull), 32'd1);
        reset = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0;
        a_rd = 5'd5; b_rd = 5'd6;
        rs1_query = 5'd2; rs2_query = 5'd10;
        @(negedge clk);
        checkOutput("flight_a_ready_in_reset", 32'(a_ready), 32'd0);
        checkOutput("flight_b_ready_in_reset", 32'(b_ready), 32'd0);
        tick;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("flight_wen_after_reset", 32'(wen), 32'd0);
        checkOutput("flight_rf_enable_after_reset", 32'(register_file_enable), 32'd0);
        checkOutput("flight_rs1_pending", 32'(rs1_pending), 32'd0);
        checkOutput("flight_rs2_pending", 32'(rs2_pending), 32'd0);
        checkOutput("flight_a_ready_after", 32'(a_ready), 32'd1);
        checkOutput("flight_b_ready_after", 32'(b_ready), 32'd1);
        for (int c = 0; c < 3; c++) begin
            tick;
            @(negedge clk);
            checkOutput("flight_no_write", 32'(wen), 32'd0);
        end
        tick;
        monitorOn = 1'b1;
        bRdList.push_back(5'd12);
        bDataList.push_back(32'hC0FFEE12);
        pushExp(5'd12, 32'hC0FFEE12);
        applyStimulus(10);
        drain("recovery_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end
endmodule
